// File: rtl/knn_sorter_ctrl.sv
// Sequencer that runs one KNN sorter through a classification pass: clear,
// stream num_pts points from memory with a fixed idle gap, then read back K indices.
module knn_sorter_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int K         = 4,
  parameter int GAP       = 4,
  localparam int SEL_W    = (K > 1) ? $clog2(K) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_pts,
  input  logic [31:0]       test_pt,
  output logic              busy,
  output logic              done,
  output logic [8*K-1:0]    result,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              srt_clr,
  output logic [31:0]       srt_data1,
  output logic [31:0]       srt_data2,
  output logic              srt_ready,
  output logic              srt_done,
  output logic [SEL_W-1:0]  srt_sel,
  input  logic [7:0]        srt_out
);

  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(K - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CLEAR, ST_FETCH, ST_WAIT, ST_STROBE, ST_GAP, ST_READ, ST_FINISH
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [ADDR_W-1:0]   idx_r, idx_nxt_s, cnt_r;
  logic                clr_cnt_r;
  logic [GAP_W-1:0]    gap_cnt_r;
  logic [SEL_W-1:0]    sel_nxt_s;
  logic                busy_r, done_r, mem_req_r, srt_clr_r, srt_ready_r, srt_done_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [SEL_W-1:0]    srt_sel_r;
  logic [31:0]         srt_data1_r, srt_data2_r;
  logic [8*K-1:0]      result_r;

  // Next-state, next point index and next read-back select
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    sel_nxt_s   = {SEL_W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_CLEAR;
          idx_nxt_s   = {ADDR_W{1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_r) begin
          if (cnt_r != {ADDR_W{1'b0}}) begin
            state_nxt_s = ST_FETCH;
          end else begin
            state_nxt_s = ST_READ;
          end
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_FETCH: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (mem_rvalid) begin
          state_nxt_s = ST_STROBE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_STROBE: begin
        idx_nxt_s = idx_r + ADDR_W'(1);
        if (GAP > 0) begin
          state_nxt_s = ST_GAP;
        end else if (idx_nxt_s == cnt_r) begin
          state_nxt_s = ST_READ;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          if (idx_r == cnt_r) begin
            state_nxt_s = ST_READ;
          end else begin
            state_nxt_s = ST_FETCH;
          end
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      ST_READ: begin
        if (srt_sel_r == SEL_LAST) begin
          state_nxt_s = ST_FINISH;
        end else begin
          state_nxt_s = ST_READ;
          sel_nxt_s   = srt_sel_r + SEL_W'(1);
        end
      end
      ST_FINISH: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // State, counters and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      idx_r       <= {ADDR_W{1'b0}};
      cnt_r       <= {ADDR_W{1'b0}};
      clr_cnt_r   <= 1'b0;
      gap_cnt_r   <= {GAP_W{1'b0}};
      srt_data1_r <= 32'h0000_0000;
      srt_data2_r <= 32'h0000_0000;
      result_r    <= {(8*K){1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      idx_r     <= idx_nxt_s;
      clr_cnt_r <= (state_r == ST_CLEAR) && !clr_cnt_r;
      gap_cnt_r <= (state_r == ST_GAP) ? gap_cnt_r + GAP_W'(1) : {GAP_W{1'b0}};
      if (state_r == ST_IDLE && start) begin
        cnt_r       <= num_pts;
        srt_data1_r <= test_pt;
      end
      if (state_r == ST_WAIT && mem_rvalid) begin
        srt_data2_r <= mem_rdata;
      end
      if (state_r == ST_READ) begin
        result_r[{srt_sel_r, 3'b000} +: 8] <= srt_out;
      end
    end
  end

  // Outputs are decoded from the next state so every strobe comes straight off a flop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      srt_clr_r   <= 1'b0;
      srt_ready_r <= 1'b0;
      srt_done_r  <= 1'b0;
      srt_sel_r   <= {SEL_W{1'b0}};
    end else begin
      busy_r      <= (state_nxt_s != ST_IDLE);
      done_r      <= (state_nxt_s == ST_FINISH);
      mem_req_r   <= (state_nxt_s == ST_FETCH);
      mem_addr_r  <= (state_nxt_s == ST_FETCH) ? BASE + idx_nxt_s : {ADDR_W{1'b0}};
      srt_clr_r   <= (state_nxt_s == ST_CLEAR);
      srt_ready_r <= (state_nxt_s == ST_STROBE);
      srt_done_r  <= (state_nxt_s == ST_READ);
      srt_sel_r   <= sel_nxt_s;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign result    = result_r;
  assign mem_req   = mem_req_r;
  assign mem_addr  = mem_addr_r;
  assign srt_clr   = srt_clr_r;
  assign srt_data1 = srt_data1_r;
  assign srt_data2 = srt_data2_r;
  assign srt_ready = srt_ready_r;
  assign srt_done  = srt_done_r;
  assign srt_sel   = srt_sel_r;

endmodule

// File: tb/tb_knn_sorter_ctrl.sv
// Bench for knn_sorter_ctrl: behavioural memory and sorter, table of runs checked
// against a distance-ranking reference, plus reset/idle hand sequences.
module tb_knn_sorter_ctrl;

  localparam int ADDR_W = 10;
  localparam int BASE   = 0;
  localparam int K      = 4;
  localparam int GAP    = 4;
  localparam int SEL_W  = 2;
  localparam int BOUND  = 4000;
  localparam int NROWS  = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] num_pts;
  logic [31:0]       test_pt;
  logic              busy, done;
  logic [8*K-1:0]    result;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              mem_rvalid;
  logic              srt_clr, srt_ready, srt_done;
  logic [31:0]       srt_data1, srt_data2;
  logic [SEL_W-1:0]  srt_sel;
  logic [7:0]        srt_out;

  int n_pass  = 0;
  int n_total = 0;

  knn_sorter_ctrl #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .K(K), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .start(start), .num_pts(num_pts), .test_pt(test_pt),
    .busy(busy), .done(done), .result(result),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .srt_clr(srt_clr), .srt_data1(srt_data1), .srt_data2(srt_data2),
    .srt_ready(srt_ready), .srt_done(srt_done), .srt_sel(srt_sel), .srt_out(srt_out)
  );

  always #5 clk = ~clk;

  // Squared Euclidean distance between two packed signed {x,y} points
  function automatic longint dist2(input logic [31:0] a, input logic [31:0] b);
    longint dx, dy;
    dx = longint'($signed(a[31:16])) - longint'($signed(b[31:16]));
    dy = longint'($signed(a[15:0]))  - longint'($signed(b[15:0]));
    return dx * dx + dy * dy;
  endfunction

  // Data memory with selectable read latency and optional spurious rvalid
  logic [31:0] mem [1024];
  bit          lat_rand = 1'b0;
  bit          spur_en  = 1'b0;
  int          nxt_lat  = 1;
  int          pend     = 0;
  logic [ADDR_W-1:0] paddr;

  always @(posedge clk) nxt_lat <= lat_rand ? int'($urandom_range(1, 5)) : 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend       <= 0;
      mem_rvalid <= 1'b0;
      mem_rdata  <= 32'h0BAD_0BAD;
    end else begin
      mem_rvalid <= 1'b0;
      mem_rdata  <= 32'h0BAD_0BAD;
      if (mem_req) begin
        if (nxt_lat == 1) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= mem[mem_addr];
        end else begin
          pend  <= nxt_lat - 1;
          paddr <= mem_addr;
        end
      end else if (pend > 0) begin
        if (pend == 1) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= mem[paddr];
        end
        pend <= pend - 1;
      end else if (spur_en && $urandom_range(0, 2) == 0) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= 32'hDEAD_BEEF;
      end
    end
  end

  // Sorter model: logs inserted distances; DATA_OUT is the index ranked SEL (ties to earlier)
  longint ins_d [256];
  int     ins_n = 0;

  always @(posedge clk) begin
    if (srt_clr) ins_n <= 0;
    else if (srt_ready && ins_n < 256) begin
      ins_d[ins_n] <= dist2(srt_data1, srt_data2);
      ins_n        <= ins_n + 1;
    end
  end

  function automatic int rank_of(input int i);
    int r;
    r = 0;
    for (int j = 0; j < ins_n; j++)
      if (ins_d[j] < ins_d[i] || (ins_d[j] == ins_d[i] && j < i)) r++;
    return r;
  endfunction

  always_comb begin
    srt_out = 8'hFF;
    for (int i = 0; i < 256; i++)
      if (i < ins_n && rank_of(i) == int'(srt_sel)) srt_out = 8'(i);
  end

  // Reference: indices of the K nearest memory points, nearest first, 0xFF when absent
  function automatic logic [8*K-1:0] ref_result(input logic [31:0] tp, input int n);
    logic [8*K-1:0] r;
    bit used [1024];
    int best;
    r = '1;
    for (int i = 0; i < 1024; i++) used[i] = 1'b0;
    for (int s = 0; s < K; s++) begin
      best = -1;
      for (int i = 0; i < n; i++)
        if (!used[i] && (best < 0 || dist2(tp, mem[BASE+i]) < dist2(tp, mem[BASE+best]))) best = i;
      if (best >= 0) begin
        used[best] = 1'b1;
        r[8*s +: 8] = 8'(best);
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  int nom_dx [5] = '{3, 0, 4, 0, 3};
  int nom_dy [5] = '{0, -1, 0, 2, -4};

  // Nominal set: distances {9,1,16,4,25} around tp
  task automatic fill_nominal(input logic [31:0] tp);
    for (int i = 0; i < 5; i++)
      mem[BASE+i] = {tp[31:16] + 16'(nom_dx[i]), tp[15:0] + 16'(nom_dy[i])};
  endtask

  typedef struct {
    logic [31:0] tp;
    int          n;
    bit          rand_pts;
    bit          lat_rnd;
    bit          spur;
    bit          hold;
    bit          use_model;
    logic [31:0] exp_res;
    int          exp_done;
  } vec_t;

  vec_t  tbl      [NROWS];
  string tbl_name [NROWS];

  task automatic run_vec(input string nm, input vec_t v);
    logic [31:0] exp_res, prev_res;
    logic        prev_done;
    int done_k, exp_done, clr_n, req_n, stb_n, rd_n;
    int bad_clr, bad_addr, bad_stb_t, bad_data, bad_sel, bad_res, bad_busy;
    for (int i = 0; i < v.n; i++) begin
      if (v.rand_pts)
        mem[BASE+i] = {16'($urandom_range(0, 600)) - 16'd300, 16'($urandom_range(0, 600)) - 16'd300};
    end
    if (!v.rand_pts) fill_nominal(v.tp);
    exp_res  = v.use_model ? ref_result(v.tp, v.n) : v.exp_res;
    exp_done = (v.exp_done > 0) ? v.exp_done : 2 + v.n * (3 + GAP) + K + 1;
    lat_rand = v.lat_rnd;
    spur_en  = v.spur;
    {done_k, clr_n, req_n, stb_n, rd_n} = '0;
    {bad_clr, bad_addr, bad_stb_t, bad_data, bad_sel, bad_res, bad_busy} = '0;
    @(negedge clk);
    prev_res  = result;
    prev_done = 1'b0;
    test_pt   = v.tp;
    num_pts   = ADDR_W'(v.n);
    start     = 1'b1;
    for (int k = 1; k <= BOUND && done_k == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start   = v.hold;
        test_pt = $urandom;
        num_pts = ADDR_W'($urandom);
      end
      if (!busy) bad_busy++;
      if (srt_clr) begin
        if (k > 2) bad_clr++;
        clr_n++;
      end
      if (mem_req) begin
        if (mem_addr !== ADDR_W'(BASE + req_n)) bad_addr++;
        req_n++;
      end
      if (srt_ready) begin
        if (!v.lat_rnd && k != 5 + stb_n * (3 + GAP)) bad_stb_t++;
        if (srt_data2 !== mem[BASE+stb_n] || srt_data1 !== v.tp) bad_data++;
        stb_n++;
      end
      if (srt_done) begin
        if (srt_sel !== SEL_W'(rd_n)) bad_sel++;
        if (!v.lat_rnd && k != exp_done - K + rd_n) bad_sel++;
        rd_n++;
      end
      if (result !== prev_res && !prev_done) bad_res++;
      prev_res  = result;
      prev_done = srt_done;
      if (done) begin
        if (srt_done || srt_sel != '0) bad_sel++;
        done_k = k;
      end
    end
    chk({nm, ".done_seen"}, 64'(done_k != 0), 64'd1);
    if (!v.lat_rnd) chk({nm, ".done_cycle"}, 64'(done_k), 64'(exp_done));
    chk({nm, ".clr_cycles"},  64'(clr_n),    64'd2);
    chk({nm, ".clr_late"},    64'(bad_clr),  64'd0);
    chk({nm, ".mem_reqs"},    64'(req_n),    64'(v.n));
    chk({nm, ".mem_addr"},    64'(bad_addr), 64'd0);
    chk({nm, ".strobes"},     64'(stb_n),    64'(v.n));
    chk({nm, ".strobe_time"}, 64'(bad_stb_t), 64'd0);
    chk({nm, ".strobe_data"}, 64'(bad_data), 64'd0);
    chk({nm, ".read_cycles"}, 64'(rd_n),     64'(K));
    chk({nm, ".read_sel"},    64'(bad_sel),  64'd0);
    chk({nm, ".busy"},        64'(bad_busy), 64'd0);
    chk({nm, ".result_hold"}, 64'(bad_res),  64'd0);
    chk({nm, ".result"},      64'(result),   64'(exp_res));
    @(negedge clk);
    chk({nm, ".idle_after"},  64'({busy, done}), 64'd0);
    start   = 1'b0;
    spur_en = 1'b0;
  endtask

  initial begin
    int cnt;
    vec_t v;
    tbl[0] = '{32'h0000_0000,  5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0200_0301, 42};
    tbl[1] = '{32'h0064_FFCE,  5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0200_0301,  0};
    tbl[2] = '{32'h1234_5678,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF,  7};
    tbl[3] = '{32'h0010_FFF0, 12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000,  0};
    tbl[4] = '{32'hFF00_0020,  3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000,  0};
    tbl[5] = '{32'h0000_0005, 30, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0000,  0};
    tbl_name = '{"nominal", "randlat_hold", "zero_pts", "rand12", "rand3", "rand30_randlat"};

    rst = 1'b1; start = 1'b0; num_pts = '0; test_pt = '0;
    #2 rst = 1'b0;
    #1;
    chk("reset_ctrl",   64'({busy, done, mem_req, srt_clr, srt_ready, srt_done, srt_sel, mem_addr}), 64'd0);
    chk("reset_data",   {srt_data1, srt_data2}, 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy || mem_req || srt_clr || done) cnt++;
    end
    chk("idle_no_start", 64'(cnt), 64'd0);

    for (int i = 0; i < NROWS; i++) run_vec(tbl_name[i], tbl[i]);

    // Reset in the WAIT state of the third point abandons the run
    lat_rand = 1'b0;
    fill_nominal(32'h0064_FFCE);
    @(negedge clk);
    test_pt = 32'h0064_FFCE; num_pts = ADDR_W'(5); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = mem_req ? 1 : 0;
    for (int k = 0; k < 200 && cnt < 3; k++) begin
      @(negedge clk);
      if (mem_req) cnt++;
    end
    chk("rst_reach_wait", 64'(cnt), 64'd3);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rst_mid_ctrl",   64'({busy, done, mem_req, srt_clr, srt_ready, srt_done, srt_sel, mem_addr}), 64'd0);
    chk("rst_mid_data",   {srt_data1, srt_data2}, 64'd0);
    chk("rst_mid_result", 64'(result), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy || done || mem_req || srt_ready) cnt++;
    end
    chk("rst_no_resume", 64'(cnt), 64'd0);
    v = tbl[0];
    run_vec("after_rst", v);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/knn_sorter_ctrl.md
Name: knn_sorter_ctrl

Overview:
- Sequencer that drives one KNN `sorter` instance through a full classification run.
- On `start` it:
  - latches the test point,
  - clears the sorter,
  - fetches `num_pts` packed {x,y} points from a data memory,
  - strobes each point into the sorter with a fixed idle gap,
  - asserts DONE and walks SEL 0..K-1 to capture the K nearest-neighbour indices into a result register.
- Sits between the host/CPU register file and the sorter datapath.

Parameters:
- ADDR_W, 10, width of point count and memory address.
- BASE_ADDR, 0, memory address of point 0.
- K, 4, neighbours read back; SEL width is clog2(K), min 1.
- GAP, 4, idle cycles after each `srt_ready` strobe before the next fetch (0 allowed).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  run request; sampled only in IDLE.
- num_pts  input  ADDR_W  points to process; latched at start.
- test_pt  input  32  {x[15:0], y[15:0]} signed; latched at start.
- busy  output  1  high from the cycle after start is accepted through FINISH.
- done  output  1  one-cycle pulse in FINISH.
- result  output  8*K  captured sorter outputs; index i at bits [8i+7:8i].
- mem_req  output  1  one-cycle read request.
- mem_addr  output  ADDR_W  BASE_ADDR + idx; valid with mem_req.
- mem_rdata  input  32  read data.
- mem_rvalid  input  1  read data valid; latency ≥1 cycle, arbitrary.
- srt_clr  output  1  active-high sorter reset.
- srt_data1  output  32  test point to sorter.
- srt_data2  output  32  current data point to sorter.
- srt_ready  output  1  one-cycle insert strobe.
- srt_done  output  1  sorter DONE.
- srt_sel  output  clog2(K)  sorter SEL.
- srt_out  input  8  sorter DATA_OUT; combinational from SEL.

Behaviour:
- Reset (rst=0, async): all outputs and internal registers go to 0, including `result`; state = IDLE. Reset mid-run abandons the run with no done pulse. Sorter contents are stale but are cleared by the next run's CLEAR.
- IDLE:
  - busy=0.
  - start=1 latches test_pt into srt_data1 and num_pts into cnt, sets idx=0, and moves to CLEAR.
  - start is ignored in every other state.
- CLEAR:
  - Lasts exactly 2 cycles with srt_clr=1.
  - Then goes to FETCH if cnt≠0, else to READ.
- FETCH:
  - Lasts 1 cycle with mem_req=1 and mem_addr=BASE_ADDR+idx.
  - Then goes to WAIT.
- WAIT:
  - Holds until mem_rvalid=1, then srt_data2<=mem_rdata and goes to STROBE.
  - mem_rvalid outside WAIT is ignored.
- STROBE:
  - Lasts 1 cycle with srt_ready=1; srt_data2 is stable for the whole cycle.
  - idx<=idx+1.
  - Then goes to GAP if GAP>0, else to the next-point decision.
- GAP:
  - GAP cycles with srt_ready=0; srt_data2 is held.
  - Next-point decision: idx==cnt goes to READ, else FETCH.
- Throughput with 1-cycle memory latency: 3+GAP cycles per point, measured strobe-to-strobe.
- READ:
  - Lasts K cycles with srt_done=1 and srt_sel=s for s=0..K-1, one value per cycle.
  - At the end of cycle s, result[s]<=srt_out.
- FINISH:
  - Lasts 1 cycle with srt_done=0, srt_sel=0, done=1, busy=1.
  - Then goes to IDLE.
- Other output rules:
  - `result` changes only during READ and holds until the next run's READ.
  - srt_data1 and srt_data2 hold their last values in IDLE.
- Arithmetic:
  - idx and cnt are ADDR_W bits.
  - num_pts = 2^ADDR_W−1 is the maximum.
  - mem_addr wraps modulo 2^ADDR_W.
- Total run length with memory latency L:
  - 2 (CLEAR) + N·(2+L+GAP) + K (READ) + 1 (FINISH) cycles after start is accepted.
  - With N=5, L=1, GAP=4, K=4: 2+5·7+4+1 = 42 cycles.

Test Plan:
1. Reset: assert rst=0 mid-clock → all outputs and `result` are 0 immediately. Release rst; start=0 → state stays IDLE, busy=0.
2. Nominal run: test_pt=(0,0), 5 points at distances {9,1,16,4,25}, L=1, GAP=4, real sorter attached.
   - Exactly 5 srt_ready pulses, 7 cycles apart; srt_data2 matches memory.
   - srt_done high 4 cycles with sel 0,1,2,3; done pulses at cycle 42.
   - result = indices {1,3,0,2}, or the sorter's documented order.
3. Variable memory latency: random mem_rvalid delays of 1–5 cycles, plus spurious rvalid in GAP and IDLE → no extra strobes; result identical to scenario 2.
4. start held high during a run and pulsed again in FINISH → ignored. Second start in IDLE → clean second run; second run's result replaces the first only during its READ.
5. num_pts=0 → 2 cycles srt_clr, no mem_req, no srt_ready, 4 READ cycles, done at cycle 7.
6. rst=0 asserted during WAIT of point 3 → busy=0, no done pulse. Following run with 5 points → correct result and exactly 5 strobes.
